// File: rtl/contador_pkg.sv
// contador_pkg: shared types and default sizing for the contador_arbitro
// scheduler and its interval counter.
package contador_pkg;

  // Scheduler states: waiting for a request, counting an interval, and the
  // single completion cycle that carries the done pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

  // Default counter width (longest interval is 2^N - 1 cycles).
  localparam int CONT_N_DEF = 6;

  // Default number of requesters sharing the counter.
  localparam int CONT_R_DEF = 2;

  // Round-robin index helper: the requester 'paso' positions after 'base',
  // wrapping modulo 'r'.
  function automatic int rr_indice(input int base, input int paso, input int r);
    return (base + paso) % r;
  endfunction

endpackage

// File: rtl/contador_carga.sv
// contador_carga: N-bit up counter with synchronous clear and count enable.
// Reset is synchronous and active-low. Clear has priority over enable.
module contador_carga
  import contador_pkg::*;
#(
  parameter int N = CONT_N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] cont
);

  // Count register: reset and clear force zero, enable advances by one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cont <= '0;
    end else if (clr) begin
      cont <= '0;
    end else if (en) begin
      cont <= cont + N'(1);
    end
  end

endmodule

// File: rtl/contador_arbitro.sv
// contador_arbitro: round-robin scheduler sharing one contador_carga interval
// counter among R requesters. A winner gets gnt for L cycles (L = its len,
// with 0 treated as 1), then a one-cycle done pulse, then the block idles.
//
// Optional feature: define CONTADOR_ABORT_EN to let the granted requester end
// its interval early by dropping req while the count is running. Without the
// macro, req is ignored during RUN and every interval runs its full length.
module contador_arbitro
  import contador_pkg::*;
#(
  parameter int N = CONT_N_DEF,
  parameter int R = CONT_R_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] len,
  output logic [R-1:0]   gnt,
  output logic [R-1:0]   done,
  output logic           busy,
  output logic [N-1:0]   cont
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  estado_t       state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [N-1:0]  lat_len;

  logic [PW-1:0] win_sel;
  logic          req_any;
  logic [N-1:0]  len_sel;
  logic          terminal;
  logic          abort;
  logic          fin_run;
  logic          cnt_clr;
  logic          cnt_en;

  function automatic logic [R-1:0] onehot(input logic [PW-1:0] i);
    logic [R-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Winner search: first set req bit after ptr, wrapping. Scanning from the
  // far end and overwriting leaves the nearest candidate as the result.
  always_comb begin
    win_sel = '0;
    req_any = 1'b0;
    for (int k = R; k >= 1; k--) begin
      if (req[rr_indice(int'(ptr), k, R)]) begin
        win_sel = PW'(rr_indice(int'(ptr), k, R));
        req_any = 1'b1;
      end
    end
  end

  assign len_sel  = len[int'(win_sel)*N +: N];
  assign terminal = (cont == (lat_len - N'(1)));

`ifdef CONTADOR_ABORT_EN
  assign abort = ~req[win_idx];
`else
  assign abort = 1'b0;
`endif

  assign fin_run = terminal | abort;

  // Counter sequencing: count only in RUN; an abort edge freezes the value,
  // every other way out of RUN and every non-RUN cycle clears it.
  always_comb begin
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    if (state == RUN) begin
      if (abort) begin
        cnt_clr = 1'b0;
      end else if (!terminal) begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
      end
    end
  end

  contador_carga #(
    .N(N)
  ) u_contador (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cont (cont)
  );

  // Scheduler FSM with registered grant, done and busy outputs; the pointer
  // moves to each new winner so it has lowest priority next time.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      ptr     <= PW'(R - 1);
      win_idx <= '0;
      lat_len <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (req_any) begin
            win_idx <= win_sel;
            ptr     <= win_sel;
            lat_len <= (len_sel == '0) ? N'(1) : len_sel;
            gnt     <= onehot(win_sel);
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (fin_run) begin
            gnt   <= '0;
            done  <= onehot(win_idx);
            state <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          done  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_arbitro.sv
// tb_contador_arbitro: scoreboard bench for contador_arbitro (N=6, R=2).
// Each test pushes the per-cycle outputs it expects, then pops and compares
// them one cycle at a time, sampling 1 ns after each rising edge.
module tb_contador_arbitro;

  localparam int N = 6;
  localparam int R = 2;

`ifdef CONTADOR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  typedef struct packed {
    logic [R-1:0] gnt;
    logic [R-1:0] done;
    logic         busy;
    logic [N-1:0] cont;
  } exp_t;

  logic           clk;
  logic           reset;
  logic [R-1:0]   req;
  logic [R*N-1:0] len;
  logic [R-1:0]   gnt;
  logic [R-1:0]   done;
  logic           busy;
  logic [N-1:0]   cont;

  exp_t exp_q[$];
  exp_t e;
  exp_t obs;
  int   checks;
  int   errors;

  contador_arbitro #(
    .N(N),
    .R(R)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .cont (cont)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_cycle(input logic [R-1:0] g, input logic [R-1:0] d,
                            input logic b, input int c);
    exp_t x;
    x.gnt  = g;
    x.done = d;
    x.busy = b;
    x.cont = N'(c);
    exp_q.push_back(x);
  endtask

  // Expected cycles for one full grant to 'who' with raw length 'l'.
  task automatic push_interval(input int who, input int l, input bit idle_after);
    logic [R-1:0] oh;
    int           eff;
    oh      = '0;
    oh[who] = 1'b1;
    eff     = (l == 0) ? 1 : l;
    for (int c = 0; c < eff; c++) push_cycle(oh, '0, 1'b1, c);
    push_cycle('0, oh, 1'b1, 0);
    if (idle_after) push_cycle('0, '0, 1'b0, 0);
  endtask

  task automatic test_reset;
    int i;
    exp_q.delete();
    push_cycle('0, '0, 1'b0, 0);
    push_cycle('0, '0, 1'b0, 0);
    push_interval(0, 2, 1'b1);
    req   = 2'b11;
    len   = {6'd3, 6'd2};
    i     = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e   = exp_q.pop_front();
      obs = {gnt, done, busy, cont};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL reset[%0d]: got gnt=%b done=%b busy=%b cont=%0d, want gnt=%b done=%b busy=%b cont=%0d",
                 i, gnt, done, busy, cont, e.gnt, e.done, e.busy, e.cont);
      end
      if (i == 1) reset = 1'b1;
      if (i == 4) req = 2'b00;
      i++;
    end
  endtask

  task automatic test_single;
    int i;
    int drop;
    exp_q.delete();
    push_interval(0, 3, 1'b1);
    drop = ABORT ? 3 : 0;
    req  = 2'b01;
    len  = {6'd9, 6'd3};
    i    = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if (i == drop) req = 2'b00;
      e   = exp_q.pop_front();
      obs = {gnt, done, busy, cont};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL single[%0d]: got gnt=%b done=%b busy=%b cont=%0d, want gnt=%b done=%b busy=%b cont=%0d",
                 i, gnt, done, busy, cont, e.gnt, e.done, e.busy, e.cont);
      end
      i++;
    end
  endtask

  task automatic test_contention;
    int i;
    exp_q.delete();
    push_cycle('0, '0, 1'b0, 0);
    push_interval(0, 2, 1'b1);
    push_interval(1, 5, 1'b1);
    push_interval(0, 2, 1'b1);
    reset = 1'b0;
    len   = {6'd5, 6'd2};
    i     = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if (i == 0) begin
        reset = 1'b1;
        req   = 2'b11;
      end
      if (i == 14) req = 2'b00;
      e   = exp_q.pop_front();
      obs = {gnt, done, busy, cont};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL contention[%0d]: got gnt=%b done=%b busy=%b cont=%0d, want gnt=%b done=%b busy=%b cont=%0d",
                 i, gnt, done, busy, cont, e.gnt, e.done, e.busy, e.cont);
      end
      i++;
    end
  endtask

  task automatic test_zero_len;
    int i;
    exp_q.delete();
    push_interval(1, 0, 1'b1);
    req = 2'b10;
    len = {6'd0, 6'd4};
    i   = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if (i == 1) req = 2'b00;
      e   = exp_q.pop_front();
      obs = {gnt, done, busy, cont};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL zero_len[%0d]: got gnt=%b done=%b busy=%b cont=%0d, want gnt=%b done=%b busy=%b cont=%0d",
                 i, gnt, done, busy, cont, e.gnt, e.done, e.busy, e.cont);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_run;
    int i;
    exp_q.delete();
    for (int c = 0; c < 5; c++) push_cycle(2'b01, '0, 1'b1, c);
    push_cycle('0, '0, 1'b0, 0);
    push_interval(0, 1, 1'b1);
    req = 2'b01;
    len = {6'd7, 6'd10};
    i   = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e   = exp_q.pop_front();
      obs = {gnt, done, busy, cont};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid_run[%0d]: got gnt=%b done=%b busy=%b cont=%0d, want gnt=%b done=%b busy=%b cont=%0d",
                 i, gnt, done, busy, cont, e.gnt, e.done, e.busy, e.cont);
      end
      if (i == 4) reset = 1'b0;
      if (i == 5) begin
        reset = 1'b1;
        req   = 2'b11;
        len   = {6'd1, 6'd1};
      end
      if (i == 7) req = 2'b00;
      i++;
    end
  endtask

  task automatic test_len_latch;
    int i;
    exp_q.delete();
    push_interval(0, 2, 1'b1);
    req = 2'b01;
    len = {6'd3, 6'd2};
    i   = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if (i == 0) len = {6'd3, 6'd7};
      if (i == 2) req = 2'b00;
      e   = exp_q.pop_front();
      obs = {gnt, done, busy, cont};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL len_latch[%0d]: got gnt=%b done=%b busy=%b cont=%0d, want gnt=%b done=%b busy=%b cont=%0d",
                 i, gnt, done, busy, cont, e.gnt, e.done, e.busy, e.cont);
      end
      i++;
    end
  endtask

  task automatic test_max_len;
    int i;
    exp_q.delete();
    push_interval(1, 63, 1'b1);
    req = 2'b10;
    len = {6'd63, 6'd1};
    i   = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if (i == 63) req = 2'b00;
      e   = exp_q.pop_front();
      obs = {gnt, done, busy, cont};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL max_len[%0d]: got gnt=%b done=%b busy=%b cont=%0d, want gnt=%b done=%b busy=%b cont=%0d",
                 i, gnt, done, busy, cont, e.gnt, e.done, e.busy, e.cont);
      end
      i++;
    end
  endtask

  task automatic test_abort;
    int i;
    exp_q.delete();
    if (ABORT) begin
      for (int c = 0; c < 4; c++) push_cycle(2'b01, '0, 1'b1, c);
      push_cycle('0, 2'b01, 1'b1, 3);
      push_cycle('0, '0, 1'b0, 0);
    end else begin
      push_interval(0, 10, 1'b1);
    end
    req = 2'b01;
    len = {6'd2, 6'd10};
    i   = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e   = exp_q.pop_front();
      obs = {gnt, done, busy, cont};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("[TB] FAIL abort[%0d]: got gnt=%b done=%b busy=%b cont=%0d, want gnt=%b done=%b busy=%b cont=%0d",
                 i, gnt, done, busy, cont, e.gnt, e.done, e.busy, e.cont);
      end
      if (i == 3) req = 2'b00;
      i++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    req    = '0;
    len    = '0;
    test_reset();
    test_single();
    test_contention();
    test_zero_len();
    test_reset_mid_run();
    test_len_latch();
    test_max_len();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
